// File: rtl/muller_pipe_pkg.sv
// Shared definitions for the clocked Muller pipeline: default sizes and the
// C-element next-state function used by every stage.
package muller_pipe_pkg;

  localparam int DEFAULT_N     = 6;
  localparam int DEFAULT_DEPTH = 4;

  // Output follows the inputs when they agree, otherwise holds its value.
  function automatic logic c_next(input logic a, input logic b, input logic y);
    return (a & b) | (y & (a | b));
  endfunction

endpackage

// File: rtl/muller_pipe_stage.sv
// One Muller pipeline stage: a registered C-element plus an N-bit data latch
// that captures only on the C-element's 0->1 (token) transition.
module muller_pipe_stage
  import muller_pipe_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         nack_i,
  input  logic [N-1:0] data_i,
  output logic         c_o,
  output logic [N-1:0] data_o
);

  logic         c_q;
  logic         c_d;
  logic [N-1:0] data_q;
  logic [N-1:0] data_d;
  logic         load;

  always_comb begin
    c_d    = c_next(req_i, nack_i, c_q);
    load   = ~c_q & c_d;
    data_d = data_q;
    // Spacer (falling) transitions keep the previously captured item.
    if (load) data_d = data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_q    <= 1'b0;
      data_q <= '0;
    end else begin
      c_q    <= c_d;
      data_q <= data_d;
    end
  end

  assign c_o    = c_q;
  assign data_o = data_q;

endmodule

// File: rtl/muller_pipe.sv
// Clocked DEPTH-stage Muller pipeline carrying N-bit bundled data under four-phase
// handshakes. Optional protocol checker enabled by MULLER_PIPE_PROTO_CHECK_EN.
module muller_pipe
  import muller_pipe_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_req,
  input  logic [N-1:0]     in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic [N-1:0]     out_data,
  input  logic             out_ack,
`ifdef MULLER_PIPE_PROTO_CHECK_EN
  output logic             proto_err,
`endif
  output logic [DEPTH-1:0] c_state
);

  logic         c_w    [DEPTH];
  logic [N-1:0] data_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic         req_w;
    logic         nack_w;
    logic [N-1:0] din_w;

    if (i == 0) begin : g_head
      assign req_w = in_req;
      assign din_w = in_data;
    end else begin : g_body
      assign req_w = c_w[i-1];
      assign din_w = data_w[i-1];
    end

    // The last stage is acknowledged by the sink rather than a successor stage.
    if (i == DEPTH - 1) begin : g_tail
      assign nack_w = ~out_ack;
    end else begin : g_link
      assign nack_w = ~c_w[i+1];
    end

    muller_pipe_stage #(.N(N)) u_stage (
      .clk_i  (wb_clk_i),
      .rst_i  (wb_rst_i),
      .req_i  (req_w),
      .nack_i (nack_w),
      .data_i (din_w),
      .c_o    (c_w[i]),
      .data_o (data_w[i])
    );

    assign c_state[i] = c_w[i];
  end

  assign in_ack   = c_w[0];
  assign out_req  = c_w[DEPTH-1];
  assign out_data = data_w[DEPTH-1];

`ifdef MULLER_PIPE_PROTO_CHECK_EN
  logic in_req_q;
  logic out_ack_q;
  logic proto_err_q;
  logic proto_err_d;
  logic violation;

  always_comb begin
    violation = ( in_req_q  & ~in_req  & ~in_ack ) |
                (~in_req_q  &  in_req  &  in_ack ) |
                (~out_ack_q &  out_ack & ~out_req) |
                ( out_ack_q & ~out_ack &  out_req);
    proto_err_d = proto_err_q | violation;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      in_req_q    <= 1'b0;
      out_ack_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      in_req_q    <= in_req;
      out_ack_q   <= out_ack;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_muller_pipe.sv
// Self-checking bench for muller_pipe: directed handshake scenarios plus a randomized
// source/sink run checked against an in-order item queue.
module tb_muller_pipe;

  localparam int N     = 6;
  localparam int DEPTH = 4;
  localparam int BUDGET = 200;
  localparam int NUM_RAND = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_req;
  logic [N-1:0]     in_data;
  logic             in_ack;
  logic             out_req;
  logic [N-1:0]     out_data;
  logic             out_ack;
  logic [DEPTH-1:0] c_state;
`ifdef MULLER_PIPE_PROTO_CHECK_EN
  logic             proto_err;
`endif

  logic [N-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  muller_pipe #(.N(N), .DEPTH(DEPTH)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .in_req   (in_req),
    .in_data  (in_data),
    .in_ack   (in_ack),
    .out_req  (out_req),
    .out_data (out_data),
    .out_ack  (out_ack),
`ifdef MULLER_PIPE_PROTO_CHECK_EN
    .proto_err(proto_err),
`endif
    .c_state  (c_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return in_ack === 1'b1;
      1:       return in_ack === 1'b0;
      2:       return out_req === 1'b1;
      3:       return out_req === 1'b0;
      default: return c_state === '0;
    endcase
  endfunction

  task automatic wait_until(input string name, input int sel, input int budget);
    int k;
    k = 0;
    while (!cond(sel) && k < budget) begin
      step();
      k++;
    end
    n_checks++;
    if (cond(sel)) n_pass++;
    else $display("FAIL %s: condition %0d not reached in %0d cycles, c_state=%b", name, sel, budget, c_state);
  endtask

  task automatic check_vec(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) $display("FAIL %s: got %h want %h", name, got, want);
    else n_pass++;
  endtask

  // Full source-side four-phase transfer of one item.
  task automatic send_item(input logic [N-1:0] d);
    wait_until("send_idle", 1, BUDGET);
    in_data = d;
    in_req  = 1'b1;
    exp_q.push_back(d);
    wait_until("send_ack", 0, BUDGET);
    in_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_req  = 1'($urandom_range(0, 1));
      out_ack = 1'($urandom_range(0, 1));
      in_data = N'($urandom);
      step();
    end
    check_vec("reset_c_state", 32'(c_state), 32'h0);
    check_vec("reset_in_ack", 32'(in_ack), 32'h0);
    check_vec("reset_out_req", 32'(out_req), 32'h0);
    check_vec("reset_out_data", 32'(out_data), 32'h0);
`ifdef MULLER_PIPE_PROTO_CHECK_EN
    check_vec("reset_proto_err", 32'(proto_err), 32'h0);
`endif
    in_req  = 1'b0;
    out_ack = 1'b0;
    in_data = '0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_item();
    in_data = 6'h2A;
    in_req  = 1'b1;
    step();
    check_vec("single_in_ack_edge0", 32'(in_ack), 32'h1);
    check_vec("single_out_req_edge0", 32'(out_req), 32'h0);
    step();
    step();
    check_vec("single_out_req_edge2", 32'(out_req), 32'h0);
    step();
    check_vec("single_out_req_edge3", 32'(out_req), 32'h1);
    check_vec("single_out_data_edge3", 32'(out_data), 32'h2A);
    in_req = 1'b0;
    wait_until("single_ack_low", 1, BUDGET);
    out_ack = 1'b1;
    wait_until("single_req_low", 3, BUDGET);
    out_ack = 1'b0;
    wait_until("single_empty", 4, BUDGET);
  endtask

  task automatic test_stall_fill();
    send_item(6'h11);
    send_item(6'h22);
    repeat (10) step();
    check_vec("stall_two_c_state", 32'(c_state), 32'hA);
    in_data = 6'h33;
    in_req  = 1'b1;
    exp_q.push_back(6'h33);
    repeat (10) step();
    check_vec("stall_c_state", 32'(c_state), 32'hA);
    check_vec("stall_in_ack", 32'(in_ack), 32'h0);
    check_vec("stall_out_data", 32'(out_data), 32'h11);
  endtask

  // Sink drains while the pending third request is finally acknowledged.
  task automatic test_drain();
    int got;
    logic [N-1:0] want;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      if (in_req && in_ack) in_req = 1'b0;
      if (!out_ack && out_req) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check_vec($sformatf("drain_item%0d", got), 32'(out_data), 32'(want));
        got++;
        out_ack = 1'b1;
      end else if (out_ack && !out_req) begin
        out_ack = 1'b0;
      end
      if (got == 3 && !out_ack && !in_req && c_state == '0) break;
      step();
    end
    check_vec("drain_count", 32'(got), 32'd3);
    check_vec("drain_final_c_state", 32'(c_state), 32'h0);
    check_vec("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic test_mid_reset();
    send_item(6'h3C);
    send_item(6'h05);
    repeat (10) step();
    check_vec("midrst_pre_c_state", 32'(c_state), 32'hA);
    do_reset();
    exp_q.delete();
    check_vec("midrst_c_state", 32'(c_state), 32'h0);
    check_vec("midrst_out_req", 32'(out_req), 32'h0);
    check_vec("midrst_out_data", 32'(out_data), 32'h0);
    step();
  endtask

`ifdef MULLER_PIPE_PROTO_CHECK_EN
  task automatic test_proto_check();
    send_item(6'h01);
    send_item(6'h02);
    repeat (10) step();
    check_vec("proto_clean", 32'(proto_err), 32'h0);
    in_req = 1'b1;
    step();
    in_req = 1'b0;
    step();
    check_vec("proto_set", 32'(proto_err), 32'h1);
    repeat (3) step();
    check_vec("proto_sticky", 32'(proto_err), 32'h1);
    do_reset();
    exp_q.delete();
    check_vec("proto_cleared", 32'(proto_err), 32'h0);
    step();
  endtask
`endif

  task automatic test_random_traffic();
    fork
      begin : source
        for (int i = 0; i < NUM_RAND; i++) begin
          repeat ($urandom_range(0, 3)) step();
          send_item(N'($urandom));
        end
      end
      begin : sink
        logic [N-1:0] want;
        for (int i = 0; i < NUM_RAND; i++) begin
          wait_until("rand_out_req", 2, BUDGET);
          repeat ($urandom_range(0, 3)) step();
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          check_vec($sformatf("rand_item%0d", i), 32'(out_data), 32'(want));
          out_ack = 1'b1;
          wait_until("rand_out_req_low", 3, BUDGET);
          repeat ($urandom_range(0, 3)) step();
          out_ack = 1'b0;
        end
      end
    join
    wait_until("rand_empty", 4, BUDGET);
    check_vec("rand_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    in_req  = 1'b0;
    in_data = '0;
    out_ack = 1'b0;
    test_reset();
    test_single_item();
    test_stall_fill();
    test_drain();
    test_mid_reset();
`ifdef MULLER_PIPE_PROTO_CHECK_EN
    test_proto_check();
`endif
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muller_pipe.md
# muller_pipe

Clocked, parametrised Muller pipeline: a chain of `DEPTH` C-element stages that carries `N`-bit bundled data under a four-phase request/acknowledge protocol on both sides. It generalises the single N-input C-element into a multi-stage handshake FIFO with data latches, in-order delivery and back-pressure. The block sits in the user project area between an input handshake source and an output sink, and is evaluated synchronously on one clock.

## Interface
- `N`, 6, data width in bits (≥1)
- `DEPTH`, 4, number of C-element stages (≥2)
- `wb_clk_i`  input  1  clock; all state updates on the rising edge
- `wb_rst_i`  input  1  reset, synchronous, active-high
- `in_req`  input  1  upstream four-phase request
- `in_data`  input  N  upstream data; must be stable from the `in_req` rise until `in_ack` is seen high
- `in_ack`  output  1  upstream acknowledge, equal to `c[0]`
- `out_req`  output  1  downstream request, equal to `c[DEPTH-1]`
- `out_data`  output  N  downstream data, equal to stage `DEPTH-1` latch
- `out_ack`  input  1  downstream four-phase acknowledge
- `c_state`  output  DEPTH  debug view of all C-element outputs, bit i = `c[i]`
- `proto_err`  output  1  sticky protocol-error flag (present only with `MULLER_PIPE_PROTO_CHECK_EN`)

## Operation
- Stage i inputs: `req_i` = `in_req` for i=0, otherwise `c[i-1]`; `nack_i` = `~c[i+1]`, or `~out_ack` for i=DEPTH-1.
- C rule per edge: both inputs 1 → 1; both 0 → 0; otherwise hold.
- All stages update simultaneously from the values registered at the previous edge. No combinational path from any input to any output.
- Data latch i loads on the edge where `c[i]` goes 0→1: stage 0 loads `in_data`, stage i loads latch i-1. Falling transitions (spacer phase) never load.
- Capacity: a stalled pipeline holds at most ceil(DEPTH/2) data items, in alternating 1/0 stage pattern ending at stage DEPTH-1 = 1.
- Order preserved; no item lost or duplicated under a legal protocol.
- Protocol legality (environment's responsibility): `in_req` rises only while `in_ack`=0 and falls only while `in_ack`=1; `out_ack` rises only while `out_req`=1 and falls only while `out_req`=0.

## Timing
- Reset: all `c`=0, all latches 0 → `in_ack`=0, `out_req`=0, `out_data`=0, `c_state`=0, `proto_err`=0 after the first edge with `wb_rst_i`=1.
- Reset has priority over every other update. Reset mid-operation discards all items. If `in_req` is still high after reset releases, it is treated as a new request on the next edge.
- `in_req` sampled high at edge k, with an empty pipeline → `in_ack`=1 after edge k; `out_req`=1 with valid `out_data` after edge k+DEPTH-1, a latency of DEPTH edges.
- Each stage advances at most one transition per edge. One token or spacer moves one stage per cycle.
- `out_ack` held 0 → pipeline fills and `in_ack` freezes; no further upstream acknowledge until downstream space opens.

## Configuration
- `MULLER_PIPE_PROTO_CHECK_EN` defined:
  - Register the previous `in_req` and `out_ack`.
  - Set `proto_err` on the next edge when any of these is seen:
    - `in_req` 1→0 while `in_ack`=0
    - `in_req` 0→1 while `in_ack`=1
    - `out_ack` 0→1 while `out_req`=0
    - `out_ack` 1→0 while `out_req`=1
  - `proto_err` is sticky; only reset clears it.
- Not defined: `proto_err` port and checker logic are absent. Datapath behaviour is identical in both builds.

## Structure
- Package `muller_pipe_pkg`: C-element next-state function `c_next(a, b, y)` and the default width/depth constants.
- Sub-module `muller_pipe_stage`: one C-element register plus an N-bit latch with rising-edge capture, instantiated DEPTH times in a generate loop.
- Top level contains the stage chain, the boundary muxing for stage 0 and stage DEPTH-1, and the optional checker.

## Test plan
- Reset: hold `wb_rst_i`=1 for 2 cycles with random inputs → `c_state`=4'b0000, `in_ack`=0, `out_req`=0, `out_data`=0.
- Single item (N=6, DEPTH=4): `in_data`=6'h2A, `in_req` rises before edge 0, `out_ack`=0 → `in_ack`=1 after edge 0; `out_req`=1 and `out_data`=6'h2A after edge 3.
- Stall fill: `out_ack` held 0; source sends 6'h11, 6'h22, 6'h33 with legal four-phase → `c_state` settles at 4'b1010, third request left unacknowledged (`in_ack`=0), `out_data`=6'h11.
- Drain: from the previous state, run sink four-phase → `out_data` sequence 6'h11, 6'h22, 6'h33 in order; final `c_state`=0.
- Reset mid-operation: with `c_state`=4'b1010, pulse `wb_rst_i` for one edge → `c_state`=0, `out_req`=0, `out_data`=0 after that edge.
- Checker (macro defined): drop `in_req` while `in_ack`=0 → `proto_err`=1 on the next edge and held until reset. Macro undefined: build succeeds with no `proto_err` port.
